// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register with valid/ready flow control, a 2-entry skid
// buffer, legacy stall-vector hold/bubble semantics, synchronous flush and a bubble counter.
//   state | meaning
//   EMPTY | no payload held, out_data presents an all-zero bubble
//   ONE   | main entry valid, skid empty
//   FULL  | main and skid valid, upstream blocked
module pipe_stage_skid #(
  parameter int DATA_W    = 80,
  parameter int STALL_W   = 6,
  parameter int STAGE_IDX = 3,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CNT_W-1:0]   bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Clamped so the unused branch never indexes below bit 0 when STAGE_IDX is 0.
  localparam int UP_IDX = (STAGE_IDX > 0) ? STAGE_IDX - 1 : 0;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;

  logic hold, up_stop, bubble, in_fire, out_fire;

  assign in_ready   = (state_q != FULL);
  assign out_valid  = (state_q != EMPTY);
  assign out_data   = main_q;
  assign bubble_cnt = bubble_cnt_q;

  always_comb begin
    hold     = stall[STAGE_IDX];
    up_stop  = (STAGE_IDX > 0) ? stall[UP_IDX] : 1'b0;
    bubble   = up_stop & ~hold;
    in_fire  = in_valid & in_ready & ~up_stop;
    out_fire = out_valid & out_ready & ~hold;
  end

  always_comb begin
    state_d      = state_q;
    main_d       = main_q;
    skid_d       = skid_q;
    bubble_cnt_d = bubble_cnt_q;

    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (out_fire) begin
            main_d  = '0;
            state_d = EMPTY;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = FULL;
          end
        end
        FULL: begin
          // Main is always older than skid, so skid slides into main on drain.
          if (out_fire) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase

      if (bubble && (bubble_cnt_q != {CNT_W{1'b1}}))
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      main_q       <= '0;
      skid_q       <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: directed scenarios with inline checks plus a payload
// scoreboard that records accepted beats and compares them against delivered beats.
module tb_pipe_stage_skid;

  localparam int DATA_W = 16;
  localparam int STALL_W = 6;
  localparam int STAGE_IDX = 3;
  localparam int CNT_W = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [CNT_W-1:0]   bubble_cnt;

  int n_checks = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] sb_q[$];

  pipe_stage_skid #(
    .DATA_W(DATA_W), .STALL_W(STALL_W), .STAGE_IDX(STAGE_IDX), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard: beats accepted upstream are queued, beats delivered downstream must match in order.
  always @(posedge clk) begin
    if (reset || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready && !stall[STAGE_IDX]) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got %h, expected no output", out_data);
        end else begin
          logic [DATA_W-1:0] exp_d;
          exp_d = sb_q.pop_front();
          if (out_data !== exp_d) begin
            n_fail++;
            $display("FAIL sb_data: got %h, expected %h", out_data, exp_d);
          end
        end
      end
      if (in_valid && in_ready && !stall[STAGE_IDX-1])
        sb_q.push_back(in_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; stall = '0; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || bubble_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset: got v=%b r=%b d=%h c=%0d, expected v=0 r=1 d=0 c=0",
               out_valid, in_ready, out_data, bubble_cnt);
    end
  endtask

  task automatic test_stream();
    out_ready = 1;
    in_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      in_data = DATA_W'(i);
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== DATA_W'(i) || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_%0d: got v=%b d=%h r=%b, expected v=1 d=%h r=1",
                 i, out_valid, out_data, in_ready, DATA_W'(i));
      end
    end
    in_valid = 0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_drain: got v=%b d=%h q=%0d, expected v=0 d=0 q=0",
               out_valid, out_data, sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1; in_valid = 1; in_data = 16'h000A;
    tick();
    out_ready = 0; in_data = 16'h000B;
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || out_data !== 16'h000A || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full: got r=%b d=%h v=%b, expected r=0 d=000a v=1", in_ready, out_data, out_valid);
    end
    in_valid = 0; out_ready = 1;
    tick();
    n_checks++;
    if (out_data !== 16'h000B || in_ready !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second: got d=%h r=%b v=%b, expected d=000b r=1 v=1", out_data, in_ready, out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL bp_empty: got v=%b d=%h, expected v=0 d=0", out_valid, out_data);
    end
  endtask

  task automatic test_hold();
    out_ready = 1; in_valid = 1; in_data = 16'h0007;
    tick();
    stall = 6'b001000; in_data = 16'h0005;
    for (int i = 0; i < 3; i++) begin
      tick();
      in_valid = 0;
      n_checks++;
      if (out_data !== 16'h0007 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_%0d: got d=%h v=%b r=%b, expected d=0007 v=1 r=0", i, out_data, out_valid, in_ready);
      end
    end
    stall = '0;
    tick();
    n_checks++;
    if (out_data !== 16'h0005 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release: got d=%h v=%b, expected d=0005 v=1", out_data, out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL hold_drain: got v=%b d=%h, expected v=0 d=0", out_valid, out_data);
    end
  endtask

  task automatic test_bubble();
    test_reset();
    out_ready = 1; in_valid = 1; in_data = 16'h0009;
    tick();
    stall = 6'b000100; in_data = 16'h00EE;
    for (int i = 1; i <= 2; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || bubble_cnt !== CNT_W'(i)) begin
        n_fail++;
        $display("FAIL bubble_%0d: got v=%b d=%h c=%0d, expected v=0 d=0 c=%0d",
                 i, out_valid, out_data, bubble_cnt, i);
      end
    end
    stall = '0; in_valid = 0;
    tick();
    n_checks++;
    if (bubble_cnt !== CNT_W'(2) || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bubble_after: got c=%0d v=%b, expected c=2 v=0", bubble_cnt, out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 0; in_valid = 1; in_data = 16'h0011;
    tick();
    in_data = 16'h0022;
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || out_data !== 16'h0011) begin
      n_fail++;
      $display("FAIL flush_setup: got r=%b d=%h, expected r=0 d=0011", in_ready, out_data);
    end
    flush = 1; in_data = 16'h0033;
    tick();
    flush = 0; in_valid = 0; out_ready = 1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1 || bubble_cnt !== CNT_W'(2)) begin
      n_fail++;
      $display("FAIL flush: got v=%b d=%h r=%b c=%0d, expected v=0 d=0 r=1 c=2",
               out_valid, out_data, in_ready, bubble_cnt);
    end
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL flush_quiet: got v=%b d=%h, expected v=0 d=0", out_valid, out_data);
    end
  endtask

  task automatic test_saturation_and_reset();
    stall = 6'b000100; in_valid = 1; in_data = 16'h00FF; out_ready = 1;
    for (int i = 1; i <= 5; i++) begin
      int exp_c;
      tick();
      exp_c = (2 + i > 3) ? 3 : 2 + i;
      n_checks++;
      if (bubble_cnt !== CNT_W'(exp_c)) begin
        n_fail++;
        $display("FAIL sat_%0d: got c=%0d, expected c=%0d", i, bubble_cnt, exp_c);
      end
    end
    stall = '0; out_ready = 0; in_data = 16'h0044;
    tick();
    in_data = 16'h0055;
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || out_data !== 16'h0044) begin
      n_fail++;
      $display("FAIL rst_setup: got r=%b d=%h, expected r=0 d=0044", in_ready, out_data);
    end
    reset = 1; in_valid = 1; in_data = 16'h0066; out_ready = 1;
    tick();
    reset = 0; in_valid = 0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || bubble_cnt !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: got v=%b r=%b d=%h c=%0d, expected v=0 r=1 d=0 c=0",
               out_valid, in_ready, out_data, bubble_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    test_reset();
    test_stream();
    test_backpressure();
    test_hold();
    test_bubble();
    test_flush();
    test_saturation_and_reset();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register. It is the next generation of the fixed-field inter-stage latch (e.g. EXE->MEM).
- The payload is one packed bus of configurable width. The stage keeps the legacy 6-bit stall-vector semantics, fixes bubble insertion, and adds valid/ready flow control with a 2-entry skid buffer.
- It also adds a synchronous flush and a bubble statistics counter.
- It sits between any two pipeline stages: upstream is stage STAGE_IDX-1, downstream is stage STAGE_IDX+1.

Parameters:
- DATA_W, 80, payload width in bits (packed control + data fields).
- STALL_W, 6, width of the pipeline stall vector.
- STAGE_IDX, 3, bit of the stall vector owned by this stage; must be in 0..STALL_W-1.
- CNT_W, 16, width of the bubble statistics counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  STALL_W  pipeline stall vector; 1 = stop.
- flush  in  1  synchronous flush of all held entries.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept a payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  main entry holds a valid payload.
- out_ready  in  1  downstream accepts the payload.
- out_data  out  DATA_W  main entry payload.
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles.

Behaviour:
- Reset and clock: reset is synchronous, active-high; clock is clk. Reset has the highest priority.
- Reset values: state EMPTY, main=0, skid=0, out_valid=0, in_ready=1, out_data=0, bubble_cnt=0.
- Definitions:
  - hold = stall[STAGE_IDX].
  - up_stop = stall[STAGE_IDX-1] when STAGE_IDX>0, else 0.
  - bubble = up_stop & ~hold.
  - in_fire = in_valid & in_ready & ~up_stop.
  - out_fire = out_valid & out_ready & ~hold.
- Outputs:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL), driven directly from registered state. There is no combinational path from out_ready or stall.
  - out_data = main register. It is forced to 0 whenever the state becomes EMPTY, so an empty stage always presents an all-zero payload (a bubble).
- State transitions (flush=0):
  - EMPTY: if in_fire, main<=in_data and go to ONE; else stay and main stays 0.
  - ONE, in_fire & out_fire: main<=in_data, stay ONE.
  - ONE, out_fire only: main<=0, go to EMPTY.
  - ONE, in_fire only: skid<=in_data, go to FULL.
  - ONE, neither: hold.
  - FULL: in_fire is impossible because in_ready=0. On out_fire: main<=skid, skid<=0, go to ONE. Otherwise hold.
- hold=1: out_fire is suppressed, so main and skid are frozen. An in_fire in the same cycle is still accepted (ONE->FULL, EMPTY->ONE). Upstream writes are never lost.
- bubble=1: upstream is treated as not valid, and in_data is ignored. The downstream entry drains normally, so a bubble propagates as out_valid=0, out_data=0.
- stall[STAGE_IDX]=1 together with stall[STAGE_IDX-1]=1 is a hold, not a bubble.
- flush=1: next state EMPTY, main=0, skid=0, regardless of in_fire, out_fire or stall. A payload presented in the flush cycle is dropped. in_ready is 1 in the following cycle.
- bubble_cnt:
  - increments by 1 on each cycle with bubble=1 and flush=0;
  - saturates at 2^CNT_W-1 with no wrap;
  - is cleared only by reset; flush does not clear it.
- Ordering: a payload is never duplicated or reordered. Main is always older than skid.
- Throughput: with hold=0, up_stop=0 and out_ready=1, the stage sustains 1 payload per cycle with 1-cycle latency.

Test Plan:
- Reset then stream: apply reset for 2 cycles, then in_valid=1 with in_data=1,2,3,4 on consecutive cycles and out_ready=1. Required: out_valid rises 1 cycle after the first beat; out_data=1,2,3,4 on consecutive cycles; in_ready stays 1.
- Backpressure/skid: in state ONE with main=0xA, drop out_ready while sending 0xB. Required: state FULL, in_ready=0 next cycle. Raise out_ready: out_data=0xA, then 0xB. No loss or duplication.
- Hold: with stall=6'b001000 (STAGE_IDX=3) for 3 cycles, a payload present and in_valid pulsed once with 0x5. Required: out_data frozen for all 3 cycles; 0x5 captured in skid; after release, the old payload then 0x5 appear in order.
- Bubble: with stall=6'b000100 for 2 cycles and in_valid=1. Required: out_valid=0 and out_data=0 after the drain; in_data ignored; bubble_cnt increases by exactly 2.
- Flush in FULL: with main=0x11, skid=0x22, assert flush together with in_valid carrying 0x33. Required: next cycle out_valid=0, out_data=0, in_ready=1; 0x11, 0x22 and 0x33 are never output.
- Counter saturation and reset mid-operation: with CNT_W=2, apply 5 bubble cycles. Required: bubble_cnt=3. Then assert reset while FULL. Required: all outputs return to reset values next cycle.
